// File: rtl/myproject_sdiv_26s_13s_16_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : myproject_sdiv_26s_13s_16_seq
// Description : Iterative signed divider (26s / 13s -> 16s quotient, 13s
//               remainder). Radix-2 restoring division on operand magnitudes,
//               one quotient bit per clock, sign correction applied when the
//               result is registered. Valid/ready handshake on both sides.
//               Fixed latency: out_vld rises DIN0_WIDTH+1 edges after accept.
//
// Ports       : ap_clk          clock, rising edge
//               ap_rst          asynchronous active-high reset
//               in_vld/in_rdy   operand handshake (din0 dividend, din1 divisor)
//               out_vld/out_rdy result handshake
//               quot, rem       signed quotient / remainder (held in DONE)
//               ovf             full quotient outside the QOUT range
//               dz              divisor was zero
//
// Build option: MYPROJECT_SDIV_SAT_EN
//               defined   -> quot saturates on overflow (non-zero divisor)
//               undefined -> quot wraps to the low QOUT_WIDTH bits
//
// Revision    : 1.0  initial release
// ============================================================================
module myproject_sdiv_26s_13s_16_seq #(
    parameter int ID         = 1,
    parameter int DIN0_WIDTH = 26,
    parameter int DIN1_WIDTH = 13,
    parameter int QOUT_WIDTH = 16,
    parameter int ROUT_WIDTH = 13
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [QOUT_WIDTH-1:0] quot,
    output logic [ROUT_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dz
);

    // Instance tag carries no function; referenced here so it is not dangling.
    localparam int c_unused_id = ID;

    localparam int                    c_cnt_w     = $clog2(DIN0_WIDTH + 1);
    localparam logic [c_cnt_w-1:0]    c_iters     = c_cnt_w'(DIN0_WIDTH);
    localparam logic [DIN0_WIDTH-1:0] c_qpos_lim  = DIN0_WIDTH'((2 ** (QOUT_WIDTH - 1)) - 1);
    localparam logic [DIN0_WIDTH-1:0] c_qneg_lim  = DIN0_WIDTH'(2 ** (QOUT_WIDTH - 1));
    localparam logic [QOUT_WIDTH-1:0] c_qmax      = {1'b0, {(QOUT_WIDTH-1){1'b1}}};
    localparam logic [QOUT_WIDTH-1:0] c_qmin      = {1'b1, {(QOUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    // Dividend magnitude; quotient bits are shifted in at the LSB as the
    // dividend bits leave at the MSB, so it ends up holding |quotient|.
    logic [DIN0_WIDTH-1:0]   r_dvd;
    logic [DIN1_WIDTH-1:0]   r_dsr;      // |divisor|, 4096 representable
    logic [DIN1_WIDTH-1:0]   r_prem;     // restored partial remainder (< |divisor|)
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_sign_q;
    logic                    r_sign_r;
    logic                    r_dz;

    logic                    w_accept;
    logic                    w_last;
    logic [DIN1_WIDTH:0]     w_shift;    // shifted partial remainder, one bit wider
    logic                    w_ge;
    logic [DIN1_WIDTH-1:0]   w_sub;
    logic [DIN0_WIDTH-1:0]   w_abs0;
    logic [DIN1_WIDTH-1:0]   w_abs1;
    logic                    w_ovf;
    logic [QOUT_WIDTH-1:0]   w_qlow;
    logic [QOUT_WIDTH-1:0]   w_qwrap;
    logic [QOUT_WIDTH-1:0]   w_qres;
    logic [ROUT_WIDTH-1:0]   w_rem;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_rdy       = 1'b0;
        out_vld      = 1'b0;
        case (r_state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    w_next_state = CALC;
                end
            end
            CALC: begin
                if (r_cnt == c_iters) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_vld = 1'b1;
                if (out_rdy) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_accept = in_vld & in_rdy;
    assign w_last   = (r_state == CALC) && (r_cnt == c_iters);

    // ------------------------------------------------------------------------
    // Restoring step. The remainder after subtraction is below |divisor|, so
    // its low DIN1_WIDTH bits are exact even though w_shift is one bit wider.
    // ------------------------------------------------------------------------
    assign w_shift = {r_prem, r_dvd[DIN0_WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dsr});
    assign w_sub   = w_shift[DIN1_WIDTH-1:0] - r_dsr;

    assign w_abs0  = din0[DIN0_WIDTH-1] ? (DIN0_WIDTH'(0) - din0) : din0;
    assign w_abs1  = din1[DIN1_WIDTH-1] ? (DIN1_WIDTH'(0) - din1) : din1;

    // ------------------------------------------------------------------------
    // Sign correction. Low bits of a negation equal the negation of the low
    // bits, so the wrapped quotient needs only the bottom QOUT_WIDTH bits.
    // ------------------------------------------------------------------------
    assign w_ovf   = r_sign_q ? (r_dvd > c_qneg_lim) : (r_dvd > c_qpos_lim);
    assign w_qlow  = r_dvd[QOUT_WIDTH-1:0];
    assign w_qwrap = r_sign_q ? (QOUT_WIDTH'(0) - w_qlow) : w_qlow;
    assign w_rem   = r_sign_r ? (ROUT_WIDTH'(0) - r_prem) : r_prem;

`ifdef MYPROJECT_SDIV_SAT_EN
    assign w_qres  = w_ovf ? (r_sign_q ? c_qmin : c_qmax) : w_qwrap;
`else
    assign w_qres  = w_qwrap;
`endif

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_prem   <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dz     <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            ovf      <= 1'b0;
            dz       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dvd    <= w_abs0;
                r_dsr    <= w_abs1;
                r_prem   <= '0;
                r_cnt    <= '0;
                r_sign_q <= din0[DIN0_WIDTH-1] ^ din1[DIN1_WIDTH-1];
                r_sign_r <= din0[DIN0_WIDTH-1];
                r_dz     <= (din1 == '0);
            end else if (w_last) begin
                dz  <= r_dz;
                ovf <= r_dz | w_ovf;
                if (r_dz) begin
                    // Divide by zero: saturate by dividend sign in both builds.
                    quot <= r_sign_r ? c_qmin : c_qmax;
                    rem  <= '0;
                end else begin
                    quot <= w_qres;
                    rem  <= w_rem;
                end
            end else if (r_state == CALC) begin
                r_prem <= w_ge ? w_sub : w_shift[DIN1_WIDTH-1:0];
                r_dvd  <= {r_dvd[DIN0_WIDTH-2:0], w_ge};
                r_cnt  <= r_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_myproject_sdiv_26s_13s_16_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_myproject_sdiv_26s_13s_16_seq
// Description : Self-checking bench for the iterative signed divider.
//               Directed cases plus randomized operands with random output
//               backpressure, compared against an arithmetic reference model
//               (integer / and %, range test, wrap or saturate).
// Revision    : 1.0  initial release
// ============================================================================
module tb_myproject_sdiv_26s_13s_16_seq;

    logic        ap_clk;
    logic        ap_rst;
    logic        in_vld;
    logic        in_rdy;
    logic [25:0] din0;
    logic [12:0] din1;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] quot;
    logic [12:0] rem;
    logic        ovf;
    logic        dz;

    int n_checks = 0;
    int n_errors = 0;

    myproject_sdiv_26s_13s_16_seq #(
        .ID         (1),
        .DIN0_WIDTH (26),
        .DIN1_WIDTH (13),
        .QOUT_WIDTH (16),
        .ROUT_WIDTH (13)
    ) u_dut (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .din0    (din0),
        .din1    (din1),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .quot    (quot),
        .rem     (rem),
        .ovf     (ovf),
        .dz      (dz)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: plain signed integer division semantics.
    function automatic void model(input longint d0, input longint d1,
                                  output longint q, output longint r,
                                  output longint o, output longint z);
        longint            qf;
        logic signed [15:0] lo;
        if (d1 == 0) begin
            z = 1; o = 1; r = 0;
            q = (d0 >= 0) ? 32767 : -32768;
        end else begin
            z  = 0;
            qf = d0 / d1;
            r  = d0 % d1;
            o  = ((qf > 32767) || (qf < -32768)) ? 1 : 0;
            lo = qf[15:0];
            q  = lo;
`ifdef MYPROJECT_SDIV_SAT_EN
            if (o != 0) q = (qf > 0) ? 32767 : -32768;
`endif
        end
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // One complete transaction: accept, latency count, optional backpressure,
    // result check, output handshake.
    task automatic do_op(input longint d0, input longint d1, input int hold);
        longint eq, er, eo, ez;
        int     w;
        int     n;
        bit     rdy_low_ok;
        bit     stable_ok;
        logic [15:0] q0;
        logic [12:0] r0;
        logic        o0, z0;

        model(d0, d1, eq, er, eo, ez);

        w = 0;
        while (!in_rdy && w < 60) begin
            tick();
            w++;
        end
        if (!in_rdy) chk("rdy_wait", 0, 1);

        in_vld = 1'b1;
        din0   = d0[25:0];
        din1   = d1[12:0];
        tick();
        in_vld = 1'b0;
        din0   = 26'($urandom);
        din1   = 13'($urandom);

        n = 0;
        rdy_low_ok = 1'b1;
        while (!out_vld && n < 100) begin
            if (in_rdy) rdy_low_ok = 1'b0;
            in_vld = 1'($urandom);
            tick();
            n++;
        end
        in_vld = 1'b0;
        chk("latency", n, 27);
        chk("in_rdy_calc", rdy_low_ok, 1);

        if (hold > 0) begin
            q0 = quot; r0 = rem; o0 = ovf; z0 = dz;
            stable_ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                in_vld = 1'($urandom);
                din0   = 26'($urandom);
                din1   = 13'($urandom);
                tick();
                if (quot !== q0 || rem !== r0 || ovf !== o0 || dz !== z0 ||
                    out_vld !== 1'b1 || in_rdy !== 1'b0)
                    stable_ok = 1'b0;
            end
            in_vld = 1'b0;
            chk("hold_stable", stable_ok, 1);
        end

        chk("quot", longint'($signed(quot)), eq);
        chk("rem", longint'($signed(rem)), er);
        chk("ovf", longint'(ovf), eo);
        chk("dz", longint'(dz), ez);

        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("vld_drop", longint'(out_vld), 0);
        chk("rdy_back", longint'(in_rdy), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic signed [25:0] s0;
        logic signed [12:0] s1;
        int  hold;
        bit  no_out;

        ap_rst  = 1'b1;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        din0    = '0;
        din1    = '0;

        #12;
        chk("rst_in_rdy", longint'(in_rdy), 1);
        chk("rst_out_vld", longint'(out_vld), 0);
        chk("rst_quot", longint'(quot), 0);
        chk("rst_rem", longint'(rem), 0);
        chk("rst_ovf", longint'(ovf), 0);
        chk("rst_dz", longint'(dz), 0);
        #10;
        ap_rst = 1'b0;
        tick();

        // Directed cases
        do_op(100, 7, 0);
        do_op(-100, 7, 0);
        do_op(100, -7, 0);
        do_op(-100, -7, 0);
        do_op(-33554432, -4096, 0);
        do_op(1000000, 3, 0);
        do_op(-1000000, 3, 0);
        do_op(500, 0, 0);
        do_op(-500, 0, 0);
        do_op(33554431, 4095, 0);
        do_op(-32768, 1, 0);
        do_op(32768, -1, 0);
        do_op(32768, 1, 0);
        do_op(100, 7, 10);

        // Reset in the middle of CALC
        in_vld = 1'b1;
        din0   = 26'd100;
        din1   = 13'd7;
        tick();
        in_vld = 1'b0;
        repeat (10) @(posedge ap_clk);
        #3;
        ap_rst = 1'b1;
        #1;
        chk("midrst_out_vld", longint'(out_vld), 0);
        chk("midrst_in_rdy", longint'(in_rdy), 1);
        @(posedge ap_clk);
        #2;
        ap_rst = 1'b0;
        no_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_vld) no_out = 1'b0;
        end
        chk("midrst_no_out", no_out, 1);
        do_op(100, 7, 0);

        // Randomized operands with random backpressure
        for (int k = 0; k < 40; k++) begin
            s0 = 26'($urandom);
            case ($urandom_range(0, 3))
                0:       s1 = 13'($urandom);
                1:       s1 = 13'($signed($urandom_range(0, 40)) - 20);
                2:       s1 = 13'($urandom_range(1000, 4095));
                default: s1 = ($urandom_range(0, 1) != 0) ? -13'sd4096 : 13'sd0;
            endcase
            if ($urandom_range(0, 3) == 0) s0 = 26'($signed($urandom_range(0, 200000)) - 100000);
            hold = int'($urandom_range(0, 3));
            do_op(longint'(s0), longint'(s1), hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
